// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
`default_nettype none

package cu_pkg;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEM       = 3'd3,
      WRITEBACK = 3'd4,
      HALTED    = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      CLS_NOP, CLS_LDI, CLS_LOAD, CLS_STORE, CLS_ALU,
      CLS_JMP, CLS_JZ, CLS_JNZ, CLS_HLT, CLS_ILL
   } op_class_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LDI   = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_STORE = 4'h3;
   localparam logic [3:0] OP_ADD   = 4'h4;
   localparam logic [3:0] OP_SUB   = 4'h5;
   localparam logic [3:0] OP_AND   = 4'h6;
   localparam logic [3:0] OP_OR    = 4'h7;
   localparam logic [3:0] OP_XOR   = 4'h8;
   localparam logic [3:0] OP_INC   = 4'h9;
   localparam logic [3:0] OP_DEC   = 4'hA;
   localparam logic [3:0] OP_JMP   = 4'hB;
   localparam logic [3:0] OP_JZ    = 4'hC;
   localparam logic [3:0] OP_JNZ   = 4'hE;
   localparam logic [3:0] OP_HLT   = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_INC = 3'b101;
   localparam logic [2:0] ALU_DEC = 3'b110;

endpackage

`default_nettype wire

// File: rtl/cu_decode.sv
// Combinational opcode decoder: instruction class, ALU operation and illegal detection.
`default_nettype none

module cu_decode
   import cu_pkg::*;
#(
   parameter int OPCODE_W = 4
) (
   input  logic [OPCODE_W-1:0] opcode,
   output op_class_t           op_class,
   output logic [2:0]          alu_sel
);

   logic [31:0] op_ext;

   always_comb begin
      op_ext   = 32'(opcode);
      op_class = CLS_ILL;
      alu_sel  = ALU_ADD;
      // Only the 16-entry map is defined; anything wider is illegal.
      if (op_ext < 32'd16) begin
         case (op_ext[3:0])
            OP_NOP:   op_class = CLS_NOP;
            OP_LDI:   op_class = CLS_LDI;
            OP_LOAD:  op_class = CLS_LOAD;
            OP_STORE: op_class = CLS_STORE;
            OP_ADD:   begin op_class = CLS_ALU; alu_sel = ALU_ADD; end
            OP_SUB:   begin op_class = CLS_ALU; alu_sel = ALU_SUB; end
            OP_AND:   begin op_class = CLS_ALU; alu_sel = ALU_AND; end
            OP_OR:    begin op_class = CLS_ALU; alu_sel = ALU_OR;  end
            OP_XOR:   begin op_class = CLS_ALU; alu_sel = ALU_XOR; end
            OP_INC:   begin op_class = CLS_ALU; alu_sel = ALU_INC; end
            OP_DEC:   begin op_class = CLS_ALU; alu_sel = ALU_DEC; end
            OP_JMP:   op_class = CLS_JMP;
            OP_JZ:    op_class = CLS_JZ;
            OP_JNZ:   op_class = CLS_JNZ;
            OP_HLT:   op_class = CLS_HLT;
            default:  op_class = CLS_ILL;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 8-bit datapath: FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// with wait-stated memory, timeout, stall, resumable halt and a retired-instruction counter.
`default_nettype none

module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter int OPCODE_W    = 4,
   parameter int ALU_OP_W    = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero_flag,
   input  logic                mem_ready,
   input  logic                stall,
   input  logic                run,
   output logic                ifetch_en,
   output logic                ir_load_en,
   output logic                alu_en,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                flag_update_en,
   output logic                reg_write_en,
   output logic                mem_read_en,
   output logic                mem_write_en,
   output logic                pc_inc_en,
   output logic                pc_load_en,
   output logic                halt,
   output logic                illegal_op,
   output logic                bus_error,
   output logic [CNT_W-1:0]    instr_retired,
   output logic [2:0]          state_dbg
);

   localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              illegal_q, illegal_d;
   logic              bus_err_q, bus_err_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   op_class_t  op_class;
   logic [2:0] alu_sel;

   logic en_ifetch, en_ir_load, en_alu, en_flag, en_reg_wr;
   logic en_mem_rd, en_mem_wr, en_pc_inc, en_pc_load, hlt_retire, timeout;

   cu_decode #(.OPCODE_W(OPCODE_W)) u_decode (
      .opcode   (opcode),
      .op_class (op_class),
      .alu_sel  (alu_sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      illegal_d  = illegal_q;
      bus_err_d  = bus_err_q;
      retired_d  = retired_q;
      en_ifetch  = 1'b0;
      en_ir_load = 1'b0;
      en_alu     = 1'b0;
      en_flag    = 1'b0;
      en_reg_wr  = 1'b0;
      en_mem_rd  = 1'b0;
      en_mem_wr  = 1'b0;
      en_pc_inc  = 1'b0;
      en_pc_load = 1'b0;
      hlt_retire = 1'b0;
      timeout    = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LIMIT) && !mem_ready;

      if (!stall) begin
         case (state_q)
            FETCH: begin
               if (mem_ready) begin
                  en_ifetch  = 1'b1;
                  en_ir_load = 1'b1;
                  wait_d     = '0;
                  state_d    = DECODE;
               end else if (timeout) begin
                  bus_err_d = 1'b1;
                  wait_d    = '0;
                  state_d   = HALTED;
               end else begin
                  en_ifetch = 1'b1;
                  wait_d    = wait_q + WAIT_W'(1);
               end
            end
            DECODE: begin
               case (op_class)
                  CLS_NOP: begin
                     en_pc_inc = 1'b1;
                     state_d   = FETCH;
                  end
                  CLS_LDI:   state_d = WRITEBACK;
                  CLS_LOAD,
                  CLS_STORE: state_d = MEM;
                  CLS_ALU, CLS_JMP, CLS_JZ, CLS_JNZ: state_d = EXECUTE;
                  CLS_HLT: begin
                     hlt_retire = 1'b1;
                     state_d    = HALTED;
                  end
                  default: begin
                     illegal_d = 1'b1;
                     state_d   = HALTED;
                  end
               endcase
            end
            EXECUTE: begin
               state_d = FETCH;
               case (op_class)
                  CLS_ALU: begin
                     en_alu  = 1'b1;
                     en_flag = 1'b1;
                     state_d = WRITEBACK;
                  end
                  CLS_JMP: en_pc_load = 1'b1;
                  CLS_JZ: begin
                     en_pc_load = zero_flag;
                     en_pc_inc  = !zero_flag;
                  end
                  CLS_JNZ: begin
                     en_pc_load = !zero_flag;
                     en_pc_inc  = zero_flag;
                  end
                  default: ;
               endcase
            end
            MEM: begin
               if (mem_ready || !timeout) begin
                  en_mem_rd = (op_class != CLS_STORE);
                  en_mem_wr = (op_class == CLS_STORE);
               end
               if (mem_ready) begin
                  wait_d = '0;
                  if (op_class == CLS_STORE) begin
                     en_pc_inc = 1'b1;
                     state_d   = FETCH;
                  end else begin
                     state_d = WRITEBACK;
                  end
               end else if (timeout) begin
                  bus_err_d = 1'b1;
                  wait_d    = '0;
                  state_d   = HALTED;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
            WRITEBACK: begin
               en_reg_wr = 1'b1;
               en_pc_inc = 1'b1;
               state_d   = FETCH;
            end
            HALTED: begin
               // A latched fault makes the halt terminal until reset.
               if (run && !illegal_q && !bus_err_q) begin
                  en_pc_inc = 1'b1;
                  state_d   = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end

      if (en_pc_inc || en_pc_load || hlt_retire) begin
         retired_d = retired_q + CNT_W'(1);
      end
   end

   // Enables are held low while reset is asserted, not just once it has been sampled.
   assign ifetch_en      = en_ifetch  & rst_n;
   assign ir_load_en     = en_ir_load & rst_n;
   assign alu_en         = en_alu     & rst_n;
   assign flag_update_en = en_flag    & rst_n;
   assign reg_write_en   = en_reg_wr  & rst_n;
   assign mem_read_en    = en_mem_rd  & rst_n;
   assign mem_write_en   = en_mem_wr  & rst_n;
   assign pc_inc_en      = en_pc_inc  & rst_n;
   assign pc_load_en     = en_pc_load & rst_n;
   assign alu_op         = (en_alu && rst_n) ? ALU_OP_W'(alu_sel) : '0;
   assign halt           = (state_q == HALTED);
   assign illegal_op     = illegal_q;
   assign bus_error      = bus_err_q;
   assign instr_retired  = retired_q;
   assign state_dbg      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction expected cycle traces built from the opcode rules.
`default_nettype none

module tb_multicycle_control_unit;

   localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                          S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

   // Expected-output vector: {ifetch, ir_load, alu, flag, reg_wr, mem_rd, mem_wr, pc_inc, pc_load, halt}
   localparam logic [9:0] B_IF  = 10'b1000000000, B_IR  = 10'b0100000000,
                          B_ALU = 10'b0010000000, B_FLG = 10'b0001000000,
                          B_RW  = 10'b0000100000, B_MR  = 10'b0000010000,
                          B_MW  = 10'b0000001000, B_INC = 10'b0000000100,
                          B_LD  = 10'b0000000010, B_HLT = 10'b0000000001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  opcode = 4'h0;
   logic        zero_flag = 1'b0, mem_ready = 1'b0, stall = 1'b0, run = 1'b0;
   logic        ifetch_en, ir_load_en, alu_en, flag_update_en, reg_write_en;
   logic        mem_read_en, mem_write_en, pc_inc_en, pc_load_en, halt;
   logic        illegal_op, bus_error;
   logic [2:0]  alu_op;
   logic [15:0] instr_retired;
   logic [2:0]  state_dbg;
   logic [9:0]  obs_vec;

   int          checks = 0, errors = 0;
   logic [15:0] exp_ret = '0;
   logic        exp_ill = 1'b0, exp_bus = 1'b0;
   bit          stall_en = 1'b0;
   logic [2:0]  forced_st = S_FETCH;
   int          forced_n = 0;

   multicycle_control_unit #(
      .OPCODE_W(4), .ALU_OP_W(3), .MEM_TIMEOUT(15), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero_flag(zero_flag),
      .mem_ready(mem_ready), .stall(stall), .run(run),
      .ifetch_en(ifetch_en), .ir_load_en(ir_load_en), .alu_en(alu_en), .alu_op(alu_op),
      .flag_update_en(flag_update_en), .reg_write_en(reg_write_en),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .pc_inc_en(pc_inc_en), .pc_load_en(pc_load_en), .halt(halt),
      .illegal_op(illegal_op), .bus_error(bus_error),
      .instr_retired(instr_retired), .state_dbg(state_dbg)
   );

   assign obs_vec = {ifetch_en, ir_load_en, alu_en, flag_update_en, reg_write_en,
                     mem_read_en, mem_write_en, pc_inc_en, pc_load_en, halt};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs just after the edge, compare at the falling edge.
   task automatic cyc(input logic [2:0] st, input logic [9:0] vec, input logic [2:0] aop,
                      input logic rdy, input logic stl, input bit hret, input logic rn);
      mem_ready = rdy;
      stall     = stl;
      run       = rn;
      @(negedge clk);
      chk("state", 32'(state_dbg), 32'(st));
      chk("enables", 32'(obs_vec), 32'(vec));
      chk("alu_op", 32'(alu_op), 32'(aop));
      chk("retired", 32'(instr_retired), 32'(exp_ret));
      chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
      chk("bus_error", 32'(bus_error), 32'(exp_bus));
      @(posedge clk);
      #1;
      if (!stl && (vec[2] || vec[1] || hret)) exp_ret = exp_ret + 16'd1;
      stall = 1'b0;
   endtask

   // A stalled cycle freezes everything except halt, whatever mem_ready/run do.
   task automatic stall_cyc(input logic [2:0] st, input logic [9:0] vec);
      cyc(st, vec & B_HLT, 3'd0, 1'($urandom), 1'b1, 1'b0, 1'($urandom));
   endtask

   task automatic step(input logic [2:0] st, input logic [9:0] vec, input logic [2:0] aop,
                       input logic rdy, input bit hret, input logic rn);
      if (forced_n > 0 && st == forced_st) begin
         for (int i = 0; i < forced_n; i++) stall_cyc(st, vec);
         forced_n = 0;
      end
      for (int i = 0; i < 3; i++) begin
         if (!(stall_en && $urandom_range(0, 5) == 0)) break;
         stall_cyc(st, vec);
      end
      cyc(st, vec, aop, rdy, 1'b0, hret, rn);
   endtask

   task automatic do_fetch(input int fw);
      for (int i = 0; i < fw; i++) begin
         opcode = 4'($urandom);
         step(S_FETCH, B_IF, 3'd0, 1'b0, 1'b0, 1'($urandom));
      end
      opcode = 4'($urandom);
      step(S_FETCH, B_IF | B_IR, 3'd0, 1'b1, 1'b0, 1'($urandom));
   endtask

   // Expected trace of one non-halting instruction, straight from the opcode table.
   task automatic do_instr(input logic [3:0] op, input logic zf, input int fw, input int mw);
      int alu_idx;
      zero_flag = zf;
      do_fetch(fw);
      opcode = op;
      if (op == 4'h0) begin
         step(S_DECODE, B_INC, 3'd0, 1'($urandom), 1'b0, 1'($urandom));
         return;
      end
      step(S_DECODE, 10'd0, 3'd0, 1'($urandom), 1'b0, 1'($urandom));
      if (op == 4'h2 || op == 4'h3) begin
         for (int i = 0; i < mw; i++)
            step(S_MEM, (op == 4'h2) ? B_MR : B_MW, 3'd0, 1'b0, 1'b0, 1'($urandom));
         if (op == 4'h2) begin
            step(S_MEM, B_MR, 3'd0, 1'b1, 1'b0, 1'($urandom));
            step(S_WB, B_RW | B_INC, 3'd0, 1'($urandom), 1'b0, 1'($urandom));
         end else begin
            step(S_MEM, B_MW | B_INC, 3'd0, 1'b1, 1'b0, 1'($urandom));
         end
      end else if (op == 4'h1) begin
         step(S_WB, B_RW | B_INC, 3'd0, 1'($urandom), 1'b0, 1'($urandom));
      end else if (op >= 4'h4 && op <= 4'hA) begin
         alu_idx = int'(op) - 4;
         step(S_EXEC, B_ALU | B_FLG, 3'(alu_idx), 1'($urandom), 1'b0, 1'($urandom));
         step(S_WB, B_RW | B_INC, 3'd0, 1'($urandom), 1'b0, 1'($urandom));
      end else if (op == 4'hB) begin
         step(S_EXEC, B_LD, 3'd0, 1'($urandom), 1'b0, 1'($urandom));
      end else if (op == 4'hC) begin
         step(S_EXEC, zf ? B_LD : B_INC, 3'd0, 1'($urandom), 1'b0, 1'($urandom));
      end else if (op == 4'hE) begin
         step(S_EXEC, zf ? B_INC : B_LD, 3'd0, 1'($urandom), 1'b0, 1'($urandom));
      end
   endtask

   task automatic do_hlt(input int fw, input int idle);
      do_fetch(fw);
      opcode = 4'hF;
      step(S_DECODE, 10'd0, 3'd0, 1'($urandom), 1'b1, 1'($urandom));
      for (int i = 0; i < idle; i++)
         step(S_HALT, B_HLT, 3'd0, 1'($urandom), 1'b0, 1'b0);
      step(S_HALT, B_HLT | B_INC, 3'd0, 1'($urandom), 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      mem_ready = 1'b0;
      stall     = 1'b0;
      run       = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(state_dbg), 32'(S_FETCH));
      chk("rst_enables", 32'(obs_vec), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_retired", 32'(instr_retired), 32'd0);
      chk("rst_faults", 32'({illegal_op, bus_error}), 32'd0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      exp_ret = '0;
      exp_ill = 1'b0;
      exp_bus = 1'b0;
   endtask

   initial begin
      logic [3:0] rop;
      @(posedge clk);
      #1;
      do_reset();

      // ADD with memory always ready: four cycles, one retirement.
      do_instr(4'h4, 1'b0, 0, 0);
      chk("add_retired", 32'(instr_retired), 32'd1);
      // LOAD with three wait cycles in MEM.
      do_instr(4'h2, 1'b0, 0, 3);
      do_instr(4'h3, 1'b1, 2, 2);
      // Conditional jumps both ways.
      do_instr(4'hC, 1'b1, 0, 0);
      do_instr(4'hC, 1'b0, 0, 0);
      do_instr(4'hE, 1'b1, 0, 0);
      do_instr(4'hE, 1'b0, 0, 0);
      do_instr(4'hB, 1'b0, 1, 0);
      // Resumable halt.
      do_hlt(0, 3);
      // Five-cycle stall parked in EXECUTE.
      forced_st = S_EXEC;
      forced_n  = 5;
      do_instr(4'h7, 1'b0, 0, 0);

      // Randomized program mix with random stalls.
      stall_en = 1'b1;
      for (int n = 0; n < 80; n++) begin
         rop = 4'($urandom_range(0, 14));
         if (rop == 4'hD) rop = 4'hE;
         else if (rop == 4'hE) rop = 4'hF;
         if (rop == 4'hF) do_hlt($urandom_range(0, 3), $urandom_range(0, 2));
         else do_instr(rop, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
      end
      stall_en = 1'b0;

      // Illegal opcode: sticky flag, run ignored.
      do_fetch(0);
      opcode = 4'hD;
      cyc(S_DECODE, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_ill = 1'b1;
      for (int i = 0; i < 3; i++) cyc(S_HALT, B_HLT, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      do_reset();

      // Fetch timeout: 15 wait cycles, then the request is dropped.
      for (int i = 0; i < 15; i++) cyc(S_FETCH, B_IF, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(S_FETCH, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_bus = 1'b1;
      for (int i = 0; i < 3; i++) cyc(S_HALT, B_HLT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      do_reset();

      // Ready arriving on the timeout cycle completes normally.
      for (int i = 0; i < 15; i++) cyc(S_FETCH, B_IF, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(S_FETCH, B_IF | B_IR, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      opcode = 4'h0;
      cyc(S_DECODE, B_INC, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset asserted in the middle of a LOAD wait.
      do_fetch(0);
      opcode = 4'h2;
      cyc(S_DECODE, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(S_MEM, B_MR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_state", 32'(state_dbg), 32'(S_MEM));
      do_reset();
      do_instr(4'h1, 1'b0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
